// File: rtl/shot_if.sv
// ----------------------------------------------------------------------------
// shot_if
// Bundles the shot stage's data signals. The master side (ship controller,
// collision stage, bench) drives the i_* signals. The slave side
// (shot_controller) drives the o_* signals.
//   i_ship_x, i_ship_y : ship position (10 bits each)
//   i_fire             : fire level from the ship controller
//   i_shot_hit         : per-slot hit from the collision stage
//   o_shot_valid       : slot i is live
//   o_shot_x/o_shot_y  : slot i position in bits [10i+9:10i]
//   o_fired            : one-cycle pulse when a spawn is accepted
//   o_pool_full        : every slot is live
// ----------------------------------------------------------------------------
interface shot_if #(
    parameter int NUM_SHOTS = 4
);
    logic [9:0]             i_ship_x;
    logic [9:0]             i_ship_y;
    logic                   i_fire;
    logic [NUM_SHOTS-1:0]   i_shot_hit;
    logic [NUM_SHOTS-1:0]   o_shot_valid;
    logic [10*NUM_SHOTS-1:0] o_shot_x;
    logic [10*NUM_SHOTS-1:0] o_shot_y;
    logic                   o_fired;
    logic                   o_pool_full;

    modport master (
        output i_ship_x, i_ship_y, i_fire, i_shot_hit,
        input  o_shot_valid, o_shot_x, o_shot_y, o_fired, o_pool_full
    );

    modport slave (
        input  i_ship_x, i_ship_y, i_fire, i_shot_hit,
        output o_shot_valid, o_shot_x, o_shot_y, o_fired, o_pool_full
    );
endinterface

// File: rtl/shot_controller.sv
// ----------------------------------------------------------------------------
// shot_controller
// Converts rising edges of the ship's fire level into player shots.
// Shots live in a fixed pool of slots and move right on a divided
// movement tick. A shot retires when its next step would pass X_MAX,
// or when the collision stage reports a hit on it.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : shot_if slave modport (ship position, fire, hits in;
//             slot state, fired pulse, pool-full out)
// ----------------------------------------------------------------------------
module shot_controller #(
    parameter int NUM_SHOTS  = 4,
    parameter int SHOT_SPEED = 25000,
    parameter int SHOT_STEP  = 4,
    parameter int NOSE_X     = 16,
    parameter int NOSE_Y     = 4,
    parameter int X_MAX      = 774,
    parameter int COOLDOWN   = 200000
) (
    input  logic  clk,
    input  logic  reset_n,
    shot_if.slave bus
);

    localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam int TK_W = $clog2(SHOT_SPEED);
    localparam logic [10:0] X_MAX_W = 11'(X_MAX);
    localparam logic [10:0] STEP_W  = 11'(SHOT_STEP);

    logic                         fire_q;
    logic [CD_W-1:0]              cool_q, cool_d;
    logic [TK_W-1:0]              tick_cnt_q, tick_cnt_d;
    logic [NUM_SHOTS-1:0]         valid_q, valid_d;
    logic [NUM_SHOTS-1:0][9:0]    x_q, x_d;
    logic [NUM_SHOTS-1:0][9:0]    y_q, y_d;
    logic                         fired_q, fired_d;

    logic                         req;
    logic                         tick;
    logic                         accept;
    logic [NUM_SHOTS-1:0]         free_oh;
    logic [10:0]                  spawn_x;

    assign req  = bus.i_fire & ~fire_q;
    assign tick = (tick_cnt_q == TK_W'(SHOT_SPEED - 1));

    // Lowest clear bit of valid_q as a one-hot vector. It is zero when the
    // pool is full. It uses this cycle's valid, so a slot freed this cycle
    // only becomes eligible for a spawn on the next cycle.
    assign free_oh = ~valid_q & (valid_q + NUM_SHOTS'(1));

    // 11-bit sum so that a ship near the right edge cannot wrap to a small x.
    assign spawn_x = {1'b0, bus.i_ship_x} + 11'(NOSE_X);

    assign accept = req && (cool_q == '0) && (|free_oh) && (spawn_x <= X_MAX_W);

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        valid_d    = valid_q;
        x_d        = x_q;
        y_d        = y_q;
        fired_d    = accept;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

        if (accept) begin
            cool_d = CD_W'(COOLDOWN - 1);
        end else if (cool_q != '0) begin
            cool_d = cool_q - 1'b1;
        end else begin
            cool_d = cool_q;
        end

        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (accept && free_oh[i]) begin
                // A slot that spawns on a tick cycle keeps its spawn position.
                valid_d[i] = 1'b1;
                x_d[i]     = spawn_x[9:0];
                y_d[i]     = bus.i_ship_y + 10'(NOSE_Y);
            end else if (bus.i_shot_hit[i] && valid_q[i]) begin
                // A hit takes priority over movement. The position is held.
                valid_d[i] = 1'b0;
            end else if (tick && valid_q[i]) begin
                if (({1'b0, x_q[i]} + STEP_W) > X_MAX_W) begin
                    valid_d[i] = 1'b0;
                end else begin
                    x_d[i] = x_q[i] + 10'(SHOT_STEP);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // Starts high, so a fire level held through reset release does
            // not look like a rising edge.
            fire_q     <= 1'b1;
            cool_q     <= '0;
            tick_cnt_q <= '0;
            valid_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            fired_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample its
            // pre-edge value, whatever the statement order.
            fire_q     <= bus.i_fire;
            cool_q     <= cool_d;
            tick_cnt_q <= tick_cnt_d;
            valid_q    <= valid_d;
            x_q        <= x_d;
            y_q        <= y_d;
            fired_q    <= fired_d;
        end
    end

    assign bus.o_shot_valid = valid_q;
    assign bus.o_shot_x     = x_q;
    assign bus.o_shot_y     = y_q;
    assign bus.o_fired      = fired_q;
    assign bus.o_pool_full  = &valid_q;

endmodule

// File: doc/shot_controller.md
# shot_controller

Projectile stage downstream of the ship controller. Turns the ship's `fire` output into player shots that travel right across the playfield. It owns a small fixed pool of shot slots and advances every live shot on a divided movement tick. Shots retire at the right screen edge, or when the collision stage reports a hit. Live shot positions feed the renderer and the collision detector.

## Interface
- `NUM_SHOTS`, 4: number of shot slots (1..8).
- `SHOT_SPEED`, 25000: clock cycles per movement tick (≥2).
- `SHOT_STEP`, 4: pixels advanced per tick.
- `NOSE_X`, 16: spawn x offset from ship x.
- `NOSE_Y`, 4: spawn y offset from ship y.
- `X_MAX`, 774: rightmost legal shot x.
- `COOLDOWN`, 200000: minimum cycles between accepted spawns.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_ship_x`  in  10  ship horizontal position.
- `i_ship_y`  in  10  ship vertical position.
- `i_fire`  in  1  fire level from ship controller.
- `i_shot_hit`  in  NUM_SHOTS  per-slot hit from the collision stage.
- `o_shot_valid`  out  NUM_SHOTS  slot i is live.
- `o_shot_x`  out  10*NUM_SHOTS  slot i x position in bits [10i+9:10i].
- `o_shot_y`  out  10*NUM_SHOTS  slot i y position, same packing.
- `o_fired`  out  1  one-cycle pulse, spawn accepted.
- `o_pool_full`  out  1  all slots valid (combinational from `o_shot_valid`).

## Operation
- Fire detect:
  - Register `fire_d` <= `i_fire`.
  - `req = i_fire & ~fire_d` (rising edge only).
  - A held fire level produces exactly one request.
- Spawn is accepted when all of the following hold:
  - `req` is asserted.
  - `cooldown == 0`.
  - At least one slot is free (taken from the current-cycle `o_shot_valid`).
  - `i_ship_x + NOSE_X <= X_MAX` (computed at 11 bits, no wrap).
- On an accepted spawn:
  - The lowest-index free slot gets valid=1, x=`i_ship_x+NOSE_X`, y=`i_ship_y+NOSE_Y` (10-bit, truncated).
  - `cooldown` loads `COOLDOWN-1`.
  - `o_fired` asserts.
- A rejected request is dropped, not queued.
- `cooldown` decrements by 1 each cycle while nonzero and saturates at 0.
- Tick counter:
  - Counts 0..SHOT_SPEED-1 and then wraps.
  - `tick` is asserted on the cycle the count equals SHOT_SPEED-1.
- Per-slot update, in priority order (highest first):
  1. Hit: `i_shot_hit[i] & valid[i]` clears valid. x/y are held.
  2. Tick with `x + SHOT_STEP > X_MAX` (11-bit compare) clears valid.
  3. Tick otherwise adds `SHOT_STEP` to x. y never changes.
- `i_shot_hit` on an invalid slot is ignored.
- A slot freed this cycle by a hit or by retirement is not eligible for spawn until the next cycle.
- A slot spawned on a tick cycle takes its spawn position and does not move on that tick.

## Timing
- All outputs are registered except `o_pool_full`.
- Reset state (asynchronous, on `reset_n` low):
  - `o_shot_valid`=0, `o_shot_x`=0, `o_shot_y`=0, `o_fired`=0.
  - tick counter=0, cooldown=0.
  - `fire_d`=1, so fire held through reset release does not spawn.
- Spawn latency: `i_fire` is first sampled high at edge k. The slot is valid, and `o_fired`=1, in the cycle after edge k. `o_fired` is low again after edge k+1.
- Hit latency: `i_shot_hit` is sampled at edge k, and valid is low after edge k.
- Movement: x changes only at edges where `tick`=1, i.e. every `SHOT_SPEED` cycles after reset.
- Reset asserted mid-flight clears all slots immediately. The tick phase restarts at 0.

## Test plan
- Spawn: bench params SHOT_SPEED=4, COOLDOWN=10; reset; ship=(272,273); rising edge on `i_fire` -> next cycle `o_fired`=1, slot0 valid at (288,277), `o_pool_full`=0.
- Held fire and cooldown: hold `i_fire` high 50 cycles -> exactly one spawn. Pulse again 5 cycles after the first spawn -> rejected. Pulse at 12 cycles -> slot1 spawns.
- Movement and retire: spawn at x=288 with SHOT_STEP=4 -> x=292 after the first tick, advancing every 4 cycles. At x=772 the next tick clears valid; x never exceeds 774.
- Pool full: spawn 4 shots spaced past cooldown -> `o_pool_full`=1. A fifth edge gives no `o_fired`. Hit slot2 -> the next edge spawns into slot2.
- Hit versus tick collision: assert `i_shot_hit[0]` on a tick cycle -> slot0 is cleared and not moved. Hit on an invalid slot -> no state change.
- Reset: `i_fire` held high across reset release -> no spawn. Assert `reset_n` low with 3 live shots -> all valid=0 asynchronously, `o_fired`=0.
